series_accumulator: RTL and testbench

SERIES_ACCUMULATOR -- requirements
Module: series_accumulator

---
 rtl/series_accumulator_if.sv | 30 +++
 rtl/series_accumulator.sv | 130 +++++++++++++
 tb/tb_series_accumulator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/series_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | series_accumulator_if : control/result bundle for series_accumulator|
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface series_accumulator_if #(
  parameter int CNT_W = 6,
  parameter int ACC_W = 16
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [CNT_W-1:0] target;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] accumulated;
  logic             overflow;

  modport master (
    output start, abort, mode, target,
    input  busy, done, count, accumulated, overflow
  );

  modport slave (
    input  start, abort, mode, target,
    output busy, done, count, accumulated, overflow
  );
endinterface
`default_nettype wire

// File: rtl/series_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | series_accumulator : iterates k=1..N folding sum k, sum k^2 or N!  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module series_accumulator #(
  parameter int CNT_W = 6,
  parameter int ACC_W = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  series_accumulator_if.slave  bus
);
  localparam int WIDE_W = ACC_W + 2 * CNT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0]  count_inc;
  logic [WIDE_W-1:0] acc_ext;
  logic [WIDE_W-1:0] term_ext;
  logic [WIDE_W-1:0] acc_next;
  logic              acc_next_ovf;

  assign count_inc = count_q + CNT_W'(1);
  assign acc_ext   = WIDE_W'(acc_q);
  assign term_ext  = WIDE_W'(count_inc);

  // Wide enough that neither k^2 nor acc*k can wrap before the range test.
  always_comb begin
    case (mode_q)
      2'b01:   acc_next = acc_ext + term_ext * term_ext;
      2'b10:   acc_next = acc_ext * term_ext;
      default: acc_next = acc_ext + term_ext;
    endcase
    acc_next_ovf = |acc_next[WIDE_W-1:ACC_W];
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_d   = bus.mode;
            target_d = bus.target;
            count_d  = '0;
            ovf_d    = 1'b0;
            acc_d    = (bus.mode == 2'b10) ? ACC_W'(1) : '0;
            state_d  = RUN;
          end
        end
        RUN: begin
          if (count_q < target_q) begin
            count_d = count_inc;
            // Saturated result is frozen; the index keeps advancing to N.
            if (!ovf_q) begin
              if (acc_next_ovf) begin
                acc_d = '1;
                ovf_d = 1'b1;
              end else begin
                acc_d = acc_next[ACC_W-1:0];
              end
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= 2'b00;
      target_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.count       = count_q;
  assign bus.accumulated = acc_q;
  assign bus.overflow    = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_series_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_series_accumulator : table + scoreboard bench for the accumulator|
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_series_accumulator;
  logic clk;
  logic rst_n;

  series_accumulator_if #(.CNT_W(6), .ACC_W(16)) bus ();

  series_accumulator #(.CNT_W(6), .ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [5:0]  target;
    logic [15:0] acc;
    logic        ovf;
    bit          mid_start;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic [5:0]  cnt;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   k;
    int   busy_n;
    bit   seen;
    e.acc = v.acc;
    e.cnt = v.target;
    e.ovf = v.ovf;
    e.lat = int'(v.target) + 1;
    sb.push_back(e);

    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = v.mode;
    bus.target = v.target;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.mode   = ~v.mode;
    bus.target = ~v.target;
    k      = 0;
    busy_n = (bus.busy === 1'b1) ? 1 : 0;
    seen   = 1'b0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      k++;
      bus.start = (v.mid_start && k == 2) ? 1'b1 : 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    bus.start = 1'b0;

    e = sb.pop_front();
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", e.lat);
    end else begin
      check("acc", 32'(bus.accumulated), 32'(e.acc));
      check("count", 32'(bus.count), 32'(e.cnt));
      check("overflow", 32'(bus.overflow), 32'(e.ovf));
      check("latency", 32'(k), 32'(e.lat));
      check("busy_cycles", 32'(busy_n), 32'(e.lat));
      @(negedge clk);
      check("done_pulse_end", 32'(bus.done), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      check("idle_hold_acc", 32'(bus.accumulated), 32'(e.acc));
      check("idle_hold_count", 32'(bus.count), 32'(e.cnt));
    end
  endtask

  task automatic check_cleared(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
    check({name, "_count"}, 32'(bus.count), 32'd0);
    check({name, "_acc"}, 32'(bus.accumulated), 32'd0);
    check({name, "_ovf"}, 32'(bus.overflow), 32'd0);
  endtask

  task automatic wait_count(input logic [5:0] c);
    int n;
    n = 0;
    while (bus.count !== c && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_count", 32'(bus.count), 32'(c));
  endtask

  initial begin
    vecs[0]  = '{2'b00, 6'd10, 16'd55,    1'b0, 1'b0};
    vecs[1]  = '{2'b01, 6'd5,  16'd55,    1'b0, 1'b0};
    vecs[2]  = '{2'b11, 6'd4,  16'd10,    1'b0, 1'b0};
    vecs[3]  = '{2'b10, 6'd8,  16'd40320, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 6'd9,  16'd65535, 1'b1, 1'b0};
    vecs[5]  = '{2'b00, 6'd0,  16'd0,     1'b0, 1'b0};
    vecs[6]  = '{2'b10, 6'd0,  16'd1,     1'b0, 1'b0};
    vecs[7]  = '{2'b01, 6'd0,  16'd0,     1'b0, 1'b0};
    vecs[8]  = '{2'b00, 6'd63, 16'd2016,  1'b0, 1'b0};
    vecs[9]  = '{2'b01, 6'd57, 16'd63365, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 6'd58, 16'd65535, 1'b1, 1'b0};
    vecs[11] = '{2'b01, 6'd63, 16'd65535, 1'b1, 1'b0};
    vecs[12] = '{2'b10, 6'd5,  16'd120,   1'b0, 1'b0};
    vecs[13] = '{2'b00, 6'd10, 16'd55,    1'b0, 1'b1};
    vecs[14] = '{2'b01, 6'd1,  16'd1,     1'b0, 1'b0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.mode   = 2'b00;
    bus.target = 6'd0;
    #12;
    check_cleared("reset");

    // Start presented in the same cycle reset releases must be taken at the next edge.
    @(negedge clk);
    rst_n      = 1'b1;
    bus.start  = 1'b1;
    bus.mode   = 2'b00;
    bus.target = 6'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_edge_start", 32'(bus.busy), 32'd1);
    repeat (6) @(negedge clk);
    check("first_run_acc", 32'(bus.accumulated), 32'd6);

    for (int i = 0; i < 15; i++) run(vecs[i]);

    // Abort mid-run at count 3.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = 2'b00;
    bus.target = 6'd10;
    @(negedge clk);
    bus.start = 1'b0;
    wait_count(6'd3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_cleared("abort");
    @(negedge clk);
    check("abort_stays_idle", 32'(bus.busy), 32'd0);

    // Abort wins over start in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_cleared("abort_prio");

    // Asynchronous reset between edges mid-run.
    bus.start  = 1'b1;
    bus.mode   = 2'b01;
    bus.target = 6'd20;
    @(negedge clk);
    bus.start = 1'b0;
    wait_count(6'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "global timeout");
  end
endmodule
`default_nettype wire
